// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch front end.
package inst_fetch_unit_pkg;

  localparam int          CORE_XLEN     = 32;
  localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST      = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_fetch_buffer.sv
// Circular FIFO holding fetched {pc, inst} pairs between memory and decode.
module fetch_buffer
  import inst_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues single-outstanding imem reads
// and queues returned {pc, inst} pairs for decode.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int             XLEN      = CORE_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(CORE_RESET_PC),
  parameter int             BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_inst,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_stall,
  output logic            misalign_err
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] addr_q;
  logic            req_q;
  logic            misalign_q;

  logic            buf_push, buf_pop;
  logic            buf_full, buf_empty;
  logic [CW-1:0]   buf_count;
  logic [CW:0]     count_after;
  logic [XLEN+31:0] buf_rdata;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_plus4;

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_plus4        = pc_q + XLEN'(4);

  // Data returned alongside a redirect belongs to the squashed path.
  assign buf_push = (state_q == WAIT) && imem_ready && !redirect_valid;
  assign buf_pop  = !buf_empty && !id_stall && !redirect_valid;

  assign count_after = {1'b0, buf_count} + (CW+1)'(1) - (CW+1)'(buf_pop);

  fetch_buffer #(
    .WIDTH (XLEN + 32),
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .flush_i (redirect_valid),
    .wdata_i ({pc_q, imem_rdata}),
    .rdata_o (buf_rdata),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign misalign_err = misalign_q;
  assign if_valid     = !buf_empty;
  assign if_pc        = buf_rdata[XLEN+31:32];
  assign if_inst      = buf_empty ? NOP_INST : buf_rdata[31:0];

  // addr_q tracks pc_q in WAIT but is frozen in DRAIN so the old request stays stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect_valid && (|redirect_pc[1:0]);
      if (redirect_valid) pc_q <= redirect_target;
      case (state_q)
        IDLE: begin
          if (redirect_valid) begin
            state_q <= WAIT;
            req_q   <= 1'b1;
            addr_q  <= redirect_target;
          end else if (!buf_full) begin
            state_q <= WAIT;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            if (imem_ready) begin
              addr_q <= redirect_target;
            end else begin
              state_q <= DRAIN;
            end
          end else if (imem_ready) begin
            pc_q <= pc_plus4;
            if (count_after < (CW+1)'(BUF_DEPTH)) begin
              addr_q <= pc_plus4;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            state_q <= WAIT;
            addr_q  <= redirect_valid ? redirect_target : pc_q;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed, table-driven bench for inst_fetch_unit with a synthetic memory image.
module tb_inst_fetch_unit;

  typedef struct {
    logic        rstN;
    logic        redir;
    logic [31:0] redirPc;
    logic        ready;
    logic        stall;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
    logic        expMis;
  } vec_t;

  logic        clock;
  logic        rstN;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic        ifValid;
  logic [31:0] ifInst;
  logic [31:0] ifPc;
  logic        idStall;
  logic        misalignErr;

  int testsRun;
  int testsFailed;
  int stepIdx;

  vec_t tbl [14];

  inst_fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clock),
    .rst_n          (rstN),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .imem_req       (imemReq),
    .imem_addr      (imemAddr),
    .imem_ready     (imemReady),
    .imem_rdata     (imemRdata),
    .if_valid       (ifValid),
    .if_inst        (ifInst),
    .if_pc          (ifPc),
    .id_stall       (idStall),
    .misalign_err   (misalignErr)
  );

  // Each address maps to a distinct, recognisable word.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[31:16]};
  endfunction

  assign imemRdata = memWord(imemAddr);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mkVec(input logic r, input logic rv, input logic [31:0] rp,
                                 input logic rdy, input logic st, input logic eReq,
                                 input logic [31:0] eAddr, input logic eVal,
                                 input logic [31:0] ePc, input logic eMis);
    vec_t v;
    v.rstN = r; v.redir = rv; v.redirPc = rp; v.ready = rdy; v.stall = st;
    v.expReq = eReq; v.expAddr = eAddr; v.expValid = eVal; v.expPc = ePc; v.expMis = eMis;
    return v;
  endfunction

  task automatic compareVal(input string name, input int idx, input logic [31:0] act,
                            input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL step%0d %s: got 0x%08h, expected 0x%08h", idx, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rstN          = v.rstN;
    redirectValid = v.redir;
    redirectPc    = v.redirPc;
    imemReady     = v.ready;
    idStall       = v.stall;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    compareVal("imem_req", idx, {31'd0, imemReq}, {31'd0, v.expReq});
    if (v.expReq) compareVal("imem_addr", idx, imemAddr, v.expAddr);
    compareVal("if_valid", idx, {31'd0, ifValid}, {31'd0, v.expValid});
    if (v.expValid) begin
      compareVal("if_pc", idx, ifPc, v.expPc);
      compareVal("if_inst", idx, ifInst, memWord(v.expPc));
    end
    compareVal("misalign_err", idx, {31'd0, misalignErr}, {31'd0, v.expMis});
  endtask

  task automatic step(input logic r, input logic rv, input logic [31:0] rp,
                      input logic rdy, input logic st, input logic eReq,
                      input logic [31:0] eAddr, input logic eVal,
                      input logic [31:0] ePc, input logic eMis);
    vec_t v;
    v = mkVec(r, rv, rp, rdy, st, eReq, eAddr, eVal, ePc, eMis);
    applyStimulus(v);
    checkOutput(v, stepIdx);
    stepIdx++;
  endtask

  initial begin
    testsRun      = 0;
    testsFailed   = 0;
    stepIdx       = 0;
    rstN          = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = '0;
    imemReady     = 1'b0;
    idStall       = 1'b0;

    // Reset, zero-wait streaming, then a 5-cycle stall that fills the buffer.
    tbl[0]  = mkVec(0, 0, 0, 1, 0,  0, 32'h00, 0, 32'h00, 0);
    tbl[1]  = mkVec(1, 0, 0, 1, 0,  1, 32'h00, 0, 32'h00, 0);
    tbl[2]  = mkVec(1, 0, 0, 1, 0,  1, 32'h04, 1, 32'h00, 0);
    tbl[3]  = mkVec(1, 0, 0, 1, 0,  1, 32'h08, 1, 32'h04, 0);
    tbl[4]  = mkVec(1, 0, 0, 1, 0,  1, 32'h0C, 1, 32'h08, 0);
    tbl[5]  = mkVec(1, 0, 0, 1, 1,  0, 32'h00, 1, 32'h08, 0);
    tbl[6]  = mkVec(1, 0, 0, 1, 1,  0, 32'h00, 1, 32'h08, 0);
    tbl[7]  = mkVec(1, 0, 0, 1, 1,  0, 32'h00, 1, 32'h08, 0);
    tbl[8]  = mkVec(1, 0, 0, 1, 1,  0, 32'h00, 1, 32'h08, 0);
    tbl[9]  = mkVec(1, 0, 0, 1, 1,  0, 32'h00, 1, 32'h08, 0);
    tbl[10] = mkVec(1, 0, 0, 1, 0,  0, 32'h00, 1, 32'h0C, 0);
    tbl[11] = mkVec(1, 0, 0, 1, 0,  1, 32'h10, 0, 32'h00, 0);
    tbl[12] = mkVec(1, 0, 0, 1, 0,  1, 32'h14, 1, 32'h10, 0);
    tbl[13] = mkVec(1, 0, 0, 1, 0,  1, 32'h18, 1, 32'h14, 0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i], stepIdx);
      stepIdx++;
    end

    // Redirect to 0x100 during the first of three wait states: old address held.
    step(1, 1, 32'h100, 0, 0,  1, 32'h018, 0, 32'h0, 0);
    step(1, 0, 32'h0,   0, 0,  1, 32'h018, 0, 32'h0, 0);
    step(1, 0, 32'h0,   0, 0,  1, 32'h018, 0, 32'h0, 0);
    step(1, 0, 32'h0,   1, 0,  1, 32'h100, 0, 32'h0, 0);
    step(1, 0, 32'h0,   1, 0,  1, 32'h104, 1, 32'h100, 0);

    // Redirect coinciding with imem_ready: returned word dropped, buffer flushed.
    step(1, 1, 32'h200, 1, 0,  1, 32'h200, 0, 32'h0, 0);
    step(1, 0, 32'h0,   1, 0,  1, 32'h204, 1, 32'h200, 0);

    // Misaligned redirect: one-cycle error pulse, fetch from aligned address.
    step(1, 1, 32'h102, 0, 0,  1, 32'h204, 0, 32'h0, 1);
    step(1, 0, 32'h0,   1, 0,  1, 32'h100, 0, 32'h0, 0);
    step(1, 0, 32'h0,   1, 0,  1, 32'h104, 1, 32'h100, 0);

    // PC wrap at the top of the address space, then reset mid-request.
    step(1, 1, 32'hFFFF_FFFC, 1, 0,  1, 32'hFFFF_FFFC, 0, 32'h0, 0);
    step(1, 0, 32'h0, 1, 0,  1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0);
    step(1, 0, 32'h0, 1, 0,  1, 32'h0000_0004, 1, 32'h0000_0000, 0);
    step(0, 0, 32'h0, 0, 0,  0, 32'h0, 0, 32'h0, 0);
    step(1, 0, 32'h0, 0, 0,  1, 32'h0000_0000, 0, 32'h0, 0);
    step(1, 0, 32'h0, 1, 0,  1, 32'h0000_0004, 1, 32'h0000_0000, 0);

    // Redirect while idle with a full, stalled buffer.
    step(1, 0, 32'h0,   1, 1,  0, 32'h0,   1, 32'h000, 0);
    step(1, 1, 32'h300, 0, 1,  1, 32'h300, 0, 32'h0,   0);
    step(1, 0, 32'h0,   1, 0,  1, 32'h304, 1, 32'h300, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
